// File: rtl/mvm_axis_loader.sv
// ---------------------------------------------------------------------------
// mvm_axis_loader
//
// AXI-stream transmitter feeding the rx port of an rtl_mvm tile. A burst
// command (op, RF select, start address, length, destination) is accepted
// first, then one data word per frame is taken from a separate data stream.
// Each word leaves as a single-beat AXIS frame carrying the rtl_mvm tuser
// encoding:
//   tuser[8:0]        target address (RF write) or start address (others)
//   tuser[10:9]       op: 11 RF write, 10 input vec, 01 reduction vec, 00 instr
//   tuser[USERW-1:11] one-hot RF select for op 11, zero otherwise
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cmd_*              burst command channel (valid/ready)
//   dat_*              data word channel (valid/ready)
//   axis_tx_*          AXIS master towards the MVM tile
//   busy               a burst is open or a beat is still waiting in the slot
//   frames_sent        completed beats (tvalid && tready), wraps at 2^32
//
// Optional build macro:
//   MVM_LOADER_TID_SEQ_EN  when defined, axis_tx_tid carries a 16-bit frame
//                          sequence number (zero-extended) that advances per
//                          completed beat; otherwise tid is constant zero.
// ---------------------------------------------------------------------------
module mvm_axis_loader #(
    parameter int DATAW   = 512,
    parameter int BYTEW   = 8,
    parameter int IDW     = 32,
    parameter int DESTW   = 12,
    parameter int USERW   = 75,
    parameter int RFDEPTH = 512,
    parameter int RFSELW  = 6,
    parameter int RFADDRW = $clog2(RFDEPTH)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RFSELW-1:0]  cmd_rf_sel,
    input  logic [RFADDRW-1:0] cmd_addr,
    input  logic [RFADDRW-1:0] cmd_len,
    input  logic [DESTW-1:0]   cmd_dest,

    input  logic               dat_valid,
    output logic               dat_ready,
    input  logic [DATAW-1:0]   dat_data,

    output logic               axis_tx_tvalid,
    output logic [DATAW-1:0]   axis_tx_tdata,
    output logic [BYTEW-1:0]   axis_tx_tstrb,
    output logic [BYTEW-1:0]   axis_tx_tkeep,
    output logic [IDW-1:0]     axis_tx_tid,
    output logic [DESTW-1:0]   axis_tx_tdest,
    output logic [USERW-1:0]   axis_tx_tuser,
    output logic               axis_tx_tlast,
    input  logic               axis_tx_tready,

    output logic               busy,
    output logic [31:0]        frames_sent
);

    localparam int NRF = USERW - 11;

    localparam logic [1:0]         OP_RF    = 2'b11;
    localparam logic [RFADDRW-1:0] ADDR_MAX = RFADDRW'(RFDEPTH - 1);
    localparam logic [RFADDRW-1:0] ADDR_ONE = RFADDRW'(1);
    localparam logic [RFADDRW-1:0] ADDR_ZERO = {RFADDRW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Assemble the rtl_mvm tuser word for one beat.
    function automatic logic [USERW-1:0] build_tuser(
        input logic [1:0]         op,
        input logic [RFSELW-1:0]  sel,
        input logic [RFADDRW-1:0] addr
    );
        logic [NRF-1:0] onehot;
        logic [8:0]     addr9;
        addr9 = 9'(addr);
        if (op == OP_RF) begin
            onehot = {{(NRF-1){1'b0}}, 1'b1} << sel;
        end else begin
            onehot = {NRF{1'b0}};
        end
        return {onehot, op, addr9};
    endfunction

    // Control and burst context
    state_t             state_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic [1:0]         op_r;
    logic [RFSELW-1:0]  rf_sel_r;
    logic [RFADDRW-1:0] addr_r;
    logic [RFADDRW-1:0] remaining_r;
    logic [DESTW-1:0]   dest_r;
    logic [31:0]        frames_sent_r;

    // Output slot
    logic               tvalid_r;
    logic [DATAW-1:0]   tdata_r;
    logic [BYTEW-1:0]   tstrb_r;
    logic [BYTEW-1:0]   tkeep_r;
    logic [DESTW-1:0]   tdest_r;
    logic [USERW-1:0]   tuser_r;
    logic               tlast_r;

    // Combinational qualifiers
    logic               cmd_fire_s;
    logic               dat_ready_s;
    logic               dat_fire_s;
    logic               beat_done_s;
    logic               nxt_tvalid_s;
    state_t             nxt_state_s;
    logic [RFADDRW-1:0] nxt_addr_s;

    // Handshake qualifiers: the slot may be refilled when empty or draining this cycle
    always_comb begin
        dat_ready_s = 1'b0;
        if (state_r == ST_BURST) begin
            dat_ready_s = !tvalid_r || axis_tx_tready;
        end else begin
            dat_ready_s = 1'b0;
        end
        cmd_fire_s  = cmd_valid && cmd_ready_r;
        dat_fire_s  = dat_valid && dat_ready_s;
        beat_done_s = tvalid_r && axis_tx_tready;
    end

    // Next slot occupancy: a refill wins over a drain so tvalid stays high
    always_comb begin
        nxt_tvalid_s = tvalid_r;
        if (dat_fire_s) begin
            nxt_tvalid_s = 1'b1;
        end else if (beat_done_s) begin
            nxt_tvalid_s = 1'b0;
        end else begin
            nxt_tvalid_s = tvalid_r;
        end
    end

    // Next FSM state: the final data accept closes the burst on the same edge
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    nxt_state_s = ST_BURST;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (dat_fire_s && (remaining_r == ADDR_ZERO)) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_BURST;
                end
            end
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // Next address: RF writes walk the register file with wrap, other ops repeat the start address
    always_comb begin
        nxt_addr_s = addr_r;
        if (op_r == OP_RF) begin
            if (addr_r == ADDR_MAX) begin
                nxt_addr_s = ADDR_ZERO;
            end else begin
                nxt_addr_s = addr_r + ADDR_ONE;
            end
        end else begin
            nxt_addr_s = addr_r;
        end
    end

    // FSM, burst context, output slot and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
            op_r          <= 2'b00;
            rf_sel_r      <= {RFSELW{1'b0}};
            addr_r        <= ADDR_ZERO;
            remaining_r   <= ADDR_ZERO;
            dest_r        <= {DESTW{1'b0}};
            frames_sent_r <= 32'd0;
            tvalid_r      <= 1'b0;
            tdata_r       <= {DATAW{1'b0}};
            tstrb_r       <= {BYTEW{1'b0}};
            tkeep_r       <= {BYTEW{1'b0}};
            tdest_r       <= {DESTW{1'b0}};
            tuser_r       <= {USERW{1'b0}};
            tlast_r       <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            cmd_ready_r <= (nxt_state_s == ST_IDLE);
            busy_r      <= (nxt_state_s != ST_IDLE) || nxt_tvalid_s;
            tvalid_r    <= nxt_tvalid_s;

            if (cmd_fire_s) begin
                op_r        <= cmd_op;
                rf_sel_r    <= cmd_rf_sel;
                addr_r      <= cmd_addr;
                remaining_r <= cmd_len;
                dest_r      <= cmd_dest;
            end else if (dat_fire_s) begin
                addr_r      <= nxt_addr_s;
                remaining_r <= remaining_r - ADDR_ONE;
            end

            // Slot fields only change on a refill, so they hold while stalled
            if (dat_fire_s) begin
                tdata_r <= dat_data;
                tstrb_r <= {BYTEW{1'b1}};
                tkeep_r <= {BYTEW{1'b1}};
                tdest_r <= dest_r;
                tuser_r <= build_tuser(op_r, rf_sel_r, addr_r);
                tlast_r <= 1'b1;
            end

            if (beat_done_s) begin
                frames_sent_r <= frames_sent_r + 32'd1;
            end
        end
    end

`ifdef MVM_LOADER_TID_SEQ_EN
    logic [15:0] seq_r;

    // Frame sequence number, advanced once per completed beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_r <= 16'd0;
        end else if (beat_done_s) begin
            seq_r <= seq_r + 16'd1;
        end
    end

    assign axis_tx_tid = {{(IDW-16){1'b0}}, seq_r};
`else
    assign axis_tx_tid = {IDW{1'b0}};
`endif

    assign cmd_ready      = cmd_ready_r;
    assign dat_ready      = dat_ready_s;
    assign busy           = busy_r;
    assign frames_sent    = frames_sent_r;
    assign axis_tx_tvalid = tvalid_r;
    assign axis_tx_tdata  = tdata_r;
    assign axis_tx_tstrb  = tstrb_r;
    assign axis_tx_tkeep  = tkeep_r;
    assign axis_tx_tdest  = tdest_r;
    assign axis_tx_tuser  = tuser_r;
    assign axis_tx_tlast  = tlast_r;

endmodule

// File: tb/tb_mvm_axis_loader.sv
// Scoreboard bench for mvm_axis_loader: the driver pushes the expected beat
// when a data word is accepted; an independent monitor pops and compares
// whenever a beat completes, and checks slot stability while stalled.
`timescale 1ns/1ps
module tb_mvm_axis_loader;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [5:0]   cmd_rf_sel;
    logic [8:0]   cmd_addr;
    logic [8:0]   cmd_len;
    logic [11:0]  cmd_dest;
    logic         dat_valid;
    logic         dat_ready;
    logic [511:0] dat_data;
    logic         axis_tx_tvalid;
    logic [511:0] axis_tx_tdata;
    logic [7:0]   axis_tx_tstrb;
    logic [7:0]   axis_tx_tkeep;
    logic [31:0]  axis_tx_tid;
    logic [11:0]  axis_tx_tdest;
    logic [74:0]  axis_tx_tuser;
    logic         axis_tx_tlast;
    logic         axis_tx_tready;
    logic         busy;
    logic [31:0]  frames_sent;

    mvm_axis_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rf_sel(cmd_rf_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_dest(cmd_dest),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
        .axis_tx_tstrb(axis_tx_tstrb), .axis_tx_tkeep(axis_tx_tkeep),
        .axis_tx_tid(axis_tx_tid), .axis_tx_tdest(axis_tx_tdest),
        .axis_tx_tuser(axis_tx_tuser), .axis_tx_tlast(axis_tx_tlast),
        .axis_tx_tready(axis_tx_tready),
        .busy(busy), .frames_sent(frames_sent)
    );

    typedef struct {
        logic [511:0] data;
        logic [74:0]  user;
        logic [11:0]  dest;
        logic [31:0]  tid;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    seq_exp  = 0;

    logic [1:0] cur_op;
    int         cur_sel;
    int         cur_addr;
    int         cur_dest;
    int         w_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    function automatic logic [74:0] exp_user(input logic [1:0] op, input int sel, input int addr);
        logic [74:0] u;
        u = '0;
        u[8:0]  = addr[8:0];
        u[10:9] = op;
        if (op == 2'b11) u[11 + sel] = 1'b1;
        return u;
    endfunction

    function automatic logic [511:0] mk_data(input int tag, input int i);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(tag * 4096 + i) ^ 32'(k * 32'h1111_0101);
        return d;
    endfunction

    // Monitor: compares completed beats with the scoreboard and checks stall stability
    initial begin
        logic [647:0] held;
        logic [647:0] now_f;
        bit           stall_prev;
        beat_t        e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            now_f = {axis_tx_tdata, axis_tx_tuser, axis_tx_tdest, axis_tx_tid,
                     axis_tx_tlast, axis_tx_tstrb, axis_tx_tkeep};
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk(axis_tx_tvalid === 1'b1, "hold_tvalid", $sformatf("%b", axis_tx_tvalid), "1");
                    chk(now_f === held, "hold_fields", $sformatf("%h", now_f), $sformatf("%h", held));
                end
                if (axis_tx_tvalid === 1'b1 && axis_tx_tready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", $sformatf("tuser=%h", axis_tx_tuser), "no beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk(axis_tx_tdata === e.data, "tdata", $sformatf("%h", axis_tx_tdata), $sformatf("%h", e.data));
                        chk(axis_tx_tuser === e.user, "tuser", $sformatf("%h", axis_tx_tuser), $sformatf("%h", e.user));
                        chk(axis_tx_tdest === e.dest, "tdest", $sformatf("%h", axis_tx_tdest), $sformatf("%h", e.dest));
                        chk(axis_tx_tid === e.tid, "tid", $sformatf("%0d", axis_tx_tid), $sformatf("%0d", e.tid));
                        chk({axis_tx_tlast, axis_tx_tstrb, axis_tx_tkeep} === 17'h1_FFFF, "last_strb_keep",
                            $sformatf("%b/%h/%h", axis_tx_tlast, axis_tx_tstrb, axis_tx_tkeep), "1/ff/ff");
                    end
                end
                if (axis_tx_tvalid === 1'b1 && axis_tx_tready === 1'b0) begin
                    chk(dat_ready === 1'b0, "dat_ready_stall", $sformatf("%b", dat_ready), "0");
                    held = now_f;
                    stall_prev = 1'b1;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input int sel, input int addr, input int len, input int dest);
        int n;
        cmd_op = op; cmd_rf_sel = sel[5:0]; cmd_addr = addr[8:0];
        cmd_len = len[8:0]; cmd_dest = dest[11:0]; cmd_valid = 1'b1;
        cur_op = op; cur_sel = sel; cur_addr = addr; cur_dest = dest; w_idx = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                chk(1'b0, "cmd_timeout", "no cmd_ready", "cmd_ready");
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int n_words, input int tag, input bit closes, output int stalls);
        beat_t e;
        int    a;
        int    n;
        stalls = 0;
        for (int i = 0; i < n_words; i++) begin
            dat_data  = mk_data(tag, i);
            dat_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (dat_ready === 1'b1) break;
                n++;
                stalls++;
                if (n > 200) begin
                    chk(1'b0, "dat_timeout", "no dat_ready", "dat_ready");
                    dat_valid = 1'b0;
                    return;
                end
            end
            a = (cur_op == 2'b11) ? ((cur_addr + w_idx) % 512) : cur_addr;
            e.data = dat_data;
            e.user = exp_user(cur_op, cur_sel, a);
            e.dest = cur_dest[11:0];
`ifdef MVM_LOADER_TID_SEQ_EN
            e.tid  = 32'(seq_exp % 65536);
`else
            e.tid  = 32'd0;
`endif
            seq_exp++;
            w_idx++;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        dat_valid = 1'b0;
        if (closes) chk(cmd_ready === 1'b1, "cmd_ready_after_last", $sformatf("%b", cmd_ready), "1");
    endtask

    task automatic wait_drain(input int exp_frames, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(exp_q.size() == 0, {name, "_drain"}, $sformatf("%0d left", exp_q.size()), "0 left");
        @(posedge clk); #1;
        chk(frames_sent === 32'(exp_frames), {name, "_frames_sent"},
            $sformatf("%0d", frames_sent), $sformatf("%0d", exp_frames));
        chk(busy === 1'b0 && axis_tx_tvalid === 1'b0, {name, "_idle"},
            $sformatf("busy=%b tvalid=%b", busy, axis_tx_tvalid), "busy=0 tvalid=0");
    endtask

    initial begin
        int st;
        int pat[4];
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rf_sel = '0; cmd_addr = '0;
        cmd_len = '0; cmd_dest = '0; dat_valid = 1'b0; dat_data = '0; axis_tx_tready = 1'b1;
        cur_op = 2'b00; cur_sel = 0; cur_addr = 0; cur_dest = 0; w_idx = 0;

        // Reset state
        #12;
        chk({axis_tx_tvalid, axis_tx_tdata, axis_tx_tuser, axis_tx_tid, axis_tx_tdest,
             axis_tx_tlast, axis_tx_tstrb, axis_tx_tkeep} === '0, "reset_tx_fields", "nonzero", "all 0");
        chk({busy, frames_sent, cmd_ready, dat_ready} === 35'd0, "reset_status",
            $sformatf("busy=%b fs=%0d cr=%b dr=%b", busy, frames_sent, cmd_ready, dat_ready), "all 0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // RF write burst, full throughput
        send_cmd(2'b11, 0, 1, 63, 12'h123);
        send_words(64, 1, 1'b1, st);
        chk(st == 0, "rf_burst_throughput", $sformatf("%0d stalls", st), "0 stalls");
        wait_drain(64, "rf_burst");

        // Address wrap 510, 511, 0, 1 with RF select 5
        send_cmd(2'b11, 5, 510, 3, 12'h055);
        send_words(4, 2, 1'b1, st);
        wait_drain(68, "wrap");

        // Backpressure, tready 1-0-0-1 then held high
        send_cmd(2'b10, 3, 0, 2, 12'h0A0);
        pat = '{1, 0, 0, 1};
        fork
            send_words(3, 3, 1'b1, st);
            begin
                for (int i = 0; i < 4; i++) begin
                    axis_tx_tready = pat[i][0];
                    @(posedge clk); #1;
                end
                axis_tx_tready = 1'b1;
            end
        join
        chk(st == 2, "bp_stall_cycles", $sformatf("%0d", st), "2");
        wait_drain(71, "backpressure");

        // Command overlap: reduction then instruction while the slot is stalled
        fork
            begin
                send_cmd(2'b01, 7, 17, 0, 12'h301);
                send_words(1, 4, 1'b1, st);
                send_cmd(2'b00, 9, 3, 0, 12'h302);
                send_words(1, 5, 1'b1, st);
            end
            begin
                axis_tx_tready = 1'b0;
                repeat (4) @(posedge clk);
                #1 axis_tx_tready = 1'b1;
            end
        join
        wait_drain(73, "overlap");

        // Asynchronous reset in the middle of an 8-word burst
        send_cmd(2'b11, 2, 100, 7, 12'h777);
        send_words(2, 6, 1'b0, st);
        #1 rst = 1'b0;
        #1;
        chk(axis_tx_tvalid === 1'b0 && busy === 1'b0, "midreset_idle",
            $sformatf("tvalid=%b busy=%b", axis_tx_tvalid, busy), "tvalid=0 busy=0");
        chk(frames_sent === 32'd0, "midreset_frames", $sformatf("%0d", frames_sent), "0");
        chk(cmd_ready === 1'b0 && dat_ready === 1'b0, "midreset_ready",
            $sformatf("cr=%b dr=%b", cmd_ready, dat_ready), "cr=0 dr=0");
        exp_q.delete();
        seq_exp = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single-word commands after reset: one frame each, tid 0, 1, 2 when enabled
        send_cmd(2'b00, 0, 5, 0, 12'h010);
        send_words(1, 7, 1'b1, st);
        wait_drain(1, "post_reset_single");
        send_cmd(2'b01, 0, 6, 0, 12'h011);
        send_words(1, 8, 1'b1, st);
        send_cmd(2'b10, 0, 7, 0, 12'h012);
        send_words(1, 9, 1'b1, st);
        wait_drain(3, "tid_seq");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
